// File: rtl/bus_phase_mux_pkg.sv
// -----------------------------------------------------------------------------
// bus_phase_mux_pkg
//
// Purpose : Shared constants and types for the bus phase multiplexer.
//           - Bit positions of the active-low CPU control signals inside
//             the control word (M1 .. BUSAK).
//           - The control-word typedef (named fields, MSB = BUSAK_n).
//           - Phase-encoding constants: the phase LSB selects between a
//             control phase (even) and an address-slice phase (odd).
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package bus_phase_mux_pkg;

    // Bit positions of the active-low control signals in the control word.
    localparam int CTRL_M1    = 0;
    localparam int CTRL_MREQ  = 1;
    localparam int CTRL_IORQ  = 2;
    localparam int CTRL_RD    = 3;
    localparam int CTRL_WR    = 4;
    localparam int CTRL_RFSH  = 5;
    localparam int CTRL_HALT  = 6;
    localparam int CTRL_BUSAK = 7;

    // Default position of wr_n inside the control word.
    localparam int WR_BIT_DEFAULT = CTRL_WR;

    // Width of the control word described by ctrl_word_t.
    localparam int CTRL_WORD_W = 8;

    // Control word with named active-low fields.
    typedef struct packed {
        logic busak_n;
        logic halt_n;
        logic rfsh_n;
        logic wr_n;
        logic rd_n;
        logic iorq_n;
        logic mreq_n;
        logic m1_n;
    } ctrl_word_t;

    // Idle control word: every active-low strobe deasserted.
    localparam ctrl_word_t CTRL_IDLE = '{default: 1'b1};

    // Phase kind, taken from the phase LSB.
    localparam logic [0:0] PH_KIND_CTRL = 1'b0;
    localparam logic [0:0] PH_KIND_ADDR = 1'b1;

    // Number of address slices and phases for a given geometry.
    function automatic int numSlices(input int addrW, input int pinW);
        return addrW / pinW;
    endfunction

    function automatic int numPhases(input int addrW, input int pinW);
        return 2 * (addrW / pinW);
    endfunction

endpackage

// File: rtl/bus_phase_mux_ctr.sv
// -----------------------------------------------------------------------------
// bus_phase_ctr
//
// Purpose : Frame phase counter for bus_phase_mux. Counts 0 .. NPH-1 while
//           enabled, wraps back to 0, and can be stretched in the last phase
//           by a hold request. Generates the CPU clock-enable pulse that
//           marks the end of a frame.
//
// Ports   :
//   clk_i      in   sole clock, rising edge
//   rst_i      in   synchronous active-high reset (priority over en/hold)
//   en_i       in   global advance enable
//   hold_i     in   frame stretch request (only honoured in phase NPH-1)
//   phase_o    out  current phase index
//   cpu_cen_o  out  combinational CPU clock-enable pulse
// -----------------------------------------------------------------------------
module bus_phase_ctr
    import bus_phase_mux_pkg::*;
#(
    parameter int NPH  = 4,
    parameter int PH_W = $clog2(NPH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            hold_i,
    output logic [PH_W-1:0] phase_o,
    output logic            cpu_cen_o
);

    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NPH - 1);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;
    logic            lastPhase;

    assign lastPhase = (phase_q == LAST_PHASE);

    // Next phase: step forward while enabled. In the last phase a hold
    // request parks the counter there; otherwise it wraps to 0. Hold in
    // any other phase has no effect.
    always_comb begin
        phase_d = phase_q;
        if (en_i) begin
            if (!lastPhase) begin
                phase_d = phase_q + PH_W'(1);
            end else if (!hold_i) begin
                phase_d = '0;
            end
        end
    end

    // Phase register; reset abandons any frame in progress, even a held one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // The CPU may step exactly when the frame is about to wrap. rst_i is
    // included so no enable leaks out during the reset cycle.
    assign cpu_cen_o = lastPhase & en_i & ~hold_i & ~rst_i;

    assign phase_o = phase_q;

endmodule

// File: rtl/bus_phase_mux.sv
// -----------------------------------------------------------------------------
// bus_phase_mux
//
// Purpose : Time-multiplexes the CPU control word and address bus onto one
//           shared pin group. Each frame alternates control / address slice:
//           phase 2k shows the control word, phase 2k+1 shows address slice k
//           (LSB slice first). The CPU is stepped once per frame via cpu_cen,
//           and the control/address snapshot is taken on that same edge, so
//           the pins always present the previous CPU cycle for a full frame.
//
// Optional feature (macro BUS_PHASE_MUX_DOE_EN):
//           when defined, the CPU write data is snapshotted alongside the
//           address and driven on data_out, with data_oe asserted whenever
//           the snapshotted wr_n is low. When undefined, data_out and data_oe
//           are tied low and no data snapshot register exists.
//
// Ports   :
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   global advance enable
//   hold         in   frame stretch request (last phase only)
//   cpu_ctrl     in   live active-low CPU control signals
//   cpu_addr     in   live CPU address bus
//   cpu_dout     in   live CPU write data
//   cpu_cen      out  CPU clock-enable pulse
//   pins_out     out  multiplexed control/address pins
//   phase        out  current phase index
//   frame_start  out  high in phase 0
//   data_out     out  snapshotted write data
//   data_oe      out  data-pin output enable
// -----------------------------------------------------------------------------
module bus_phase_mux
    import bus_phase_mux_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int PIN_W  = 8,
    parameter int CTRL_W = 8,
    parameter int WR_BIT = WR_BIT_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   hold,
    input  logic [CTRL_W-1:0]                      cpu_ctrl,
    input  logic [ADDR_W-1:0]                      cpu_addr,
    input  logic [PIN_W-1:0]                       cpu_dout,
    output logic                                   cpu_cen,
    output logic [PIN_W-1:0]                       pins_out,
    output logic [$clog2(2*(ADDR_W/PIN_W))-1:0]    phase,
    output logic                                   frame_start,
    output logic [PIN_W-1:0]                       data_out,
    output logic [PIN_W-1:0]                       data_oe
);

    localparam int NSLICE = numSlices(ADDR_W, PIN_W);
    localparam int NPH    = numPhases(ADDR_W, PIN_W);
    localparam int PH_W   = $clog2(NPH);

    // Reject geometries the pin multiplexer cannot represent.
    generate
        if ((ADDR_W % PIN_W) != 0 || CTRL_W != PIN_W || WR_BIT >= CTRL_W) begin : gBadParams
            $error("bus_phase_mux: ADDR_W must be a multiple of PIN_W, CTRL_W must equal PIN_W, WR_BIT must be inside the control word");
        end
    endgenerate

    logic [PH_W-1:0]   phase_q;
    logic              cpuCen;

    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [PIN_W-1:0]  pinsMux;

    // Phase counter and CPU clock-enable generation.
    bus_phase_ctr #(
        .NPH  (NPH),
        .PH_W (PH_W)
    ) uCtr (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .hold_i    (hold),
        .phase_o   (phase_q),
        .cpu_cen_o (cpuCen)
    );

    // Snapshot the live CPU bus on the same edge the CPU is stepped.
    always_comb begin
        ctrl_d = ctrl_q;
        addr_d = addr_q;
        if (cpuCen) begin
            ctrl_d = cpu_ctrl;
            addr_d = cpu_addr;
        end
    end

    // Reset parks the pins on an idle (all strobes high) control word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '1;
            addr_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            addr_q <= addr_d;
        end
    end

    // Pin selection: even phases show the control word, phase 2k+1 shows
    // address slice k. Built only from registered state so the pins never
    // follow the live CPU inputs.
    always_comb begin
        pinsMux = ctrl_q;
        for (int k = 0; k < NSLICE; k++) begin
            if (phase_q == PH_W'(2 * k + 1)) begin
                pinsMux = addr_q[k*PIN_W +: PIN_W];
            end
        end
    end

    assign pins_out    = pinsMux;
    assign phase       = phase_q;
    assign cpu_cen     = cpuCen;
    assign frame_start = (phase_q == '0);

`ifdef BUS_PHASE_MUX_DOE_EN
    logic [PIN_W-1:0] dout_q;
    logic [PIN_W-1:0] dout_d;

    // Write data is captured together with the control/address snapshot.
    always_comb begin
        dout_d = dout_q;
        if (cpuCen) begin
            dout_d = cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // Drive the data pins only while the snapshotted cycle is a write.
    assign data_out = dout_q;
    assign data_oe  = {PIN_W{~ctrl_q[WR_BIT]}};
`else
    // Data path compiled out; write data is intentionally ignored.
    logic unusedDout;
    assign unusedDout = ^cpu_dout;

    assign data_out = '0;
    assign data_oe  = '0;
`endif

endmodule

// File: tb/tb_bus_phase_mux.sv
// -----------------------------------------------------------------------------
// tb_bus_phase_mux
//
// Directed bench for bus_phase_mux: a default 16-bit instance and a 24-bit
// address instance sharing clock, reset, hold and control inputs.
// Honours BUS_PHASE_MUX_DOE_EN for the data-path expectations.
// -----------------------------------------------------------------------------
module tb_bus_phase_mux;

`ifdef BUS_PHASE_MUX_DOE_EN
    localparam bit DOE = 1'b1;
`else
    localparam bit DOE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        en24;
    logic        hold;
    logic [7:0]  cpuCtrl;
    logic [15:0] addr16;
    logic [23:0] addr24;
    logic [7:0]  cpuDout;

    logic        cen16;
    logic [7:0]  pins16;
    logic [1:0]  phase16;
    logic        fs16;
    logic [7:0]  dout16;
    logic [7:0]  doe16;

    logic        cen24;
    logic [7:0]  pins24;
    logic [2:0]  phase24;
    logic        fs24;
    logic [7:0]  dout24;
    logic [7:0]  doe24;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp16 [4] = '{8'hEF, 8'h34, 8'hEF, 8'h12};
    logic [7:0] exp24 [6] = '{8'hEF, 8'hEF, 8'hEF, 8'hCD, 8'hEF, 8'hAB};

    bus_phase_mux dut16 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hold        (hold),
        .cpu_ctrl    (cpuCtrl),
        .cpu_addr    (addr16),
        .cpu_dout    (cpuDout),
        .cpu_cen     (cen16),
        .pins_out    (pins16),
        .phase       (phase16),
        .frame_start (fs16),
        .data_out    (dout16),
        .data_oe     (doe16)
    );

    bus_phase_mux #(.ADDR_W(24)) dut24 (
        .clk         (clk),
        .rst         (rst),
        .en          (en24),
        .hold        (hold),
        .cpu_ctrl    (cpuCtrl),
        .cpu_addr    (addr24),
        .cpu_dout    (cpuDout),
        .cpu_cen     (cen24),
        .pins_out    (pins24),
        .phase       (phase24),
        .frame_start (fs24),
        .data_out    (dout24),
        .data_oe     (doe24)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance a number of rising edges, then settle 1 ns past the edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One comparison: count it, and report on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        en24    = 1'b0;
        hold    = 1'b0;
        cpuCtrl = 8'hEF;
        addr16  = 16'h1234;
        addr24  = 24'hABCDEF;
        cpuDout = 8'h5A;
        applyStimulus(2);

        // Reset state.
        checkOutput("rst_phase", 32'(phase16), 32'd0);
        checkOutput("rst_pins", 32'(pins16), 32'hFF);
        checkOutput("rst_cen", 32'(cen16), 32'd0);
        checkOutput("rst_fs", 32'(fs16), 32'd1);
        checkOutput("rst_dout", 32'(dout16), 32'd0);
        checkOutput("rst_doe", 32'(doe16), 32'd0);

        // Free-running frames: first frame shows the reset snapshot, later
        // frames show EF/34/EF/12 with one cpu_cen every 4 clocks.
        rst = 1'b0;
        en  = 1'b1;
        #1;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) begin
                checkOutput("run_phase", 32'(phase16), 32'(p));
                checkOutput("run_pins", 32'(pins16),
                            (f == 0) ? ((p % 2 == 1) ? 32'h00 : 32'hFF) : 32'(exp16[p]));
                checkOutput("run_cen", 32'(cen16), (p == 3) ? 32'd1 : 32'd0);
                checkOutput("run_fs", 32'(fs16), (p == 0) ? 32'd1 : 32'd0);
                if (f == 1 && p == 0) begin
                    checkOutput("doe_wr", 32'(doe16), DOE ? 32'hFF : 32'h00);
                    checkOutput("dout_wr", 32'(dout16), DOE ? 32'h5A : 32'h00);
                end
                applyStimulus(1);
            end
        end

        // Hold in phase 3 for 3 clocks; new address must not be captured.
        applyStimulus(3);
        hold   = 1'b1;
        addr16 = 16'h5678;
        #1;
        checkOutput("hold_phase0", 32'(phase16), 32'd3);
        checkOutput("hold_cen0", 32'(cen16), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("hold_phase", 32'(phase16), 32'd3);
            checkOutput("hold_cen", 32'(cen16), 32'd0);
            checkOutput("hold_pins", 32'(pins16), 32'h12);
        end
        hold = 1'b0;
        #1;
        checkOutput("hold_release_cen", 32'(cen16), 32'd1);
        checkOutput("hold_release_phase", 32'(phase16), 32'd3);
        applyStimulus(1);
        checkOutput("post_hold_ph0", 32'(pins16), 32'hEF);
        applyStimulus(1);
        checkOutput("post_hold_ph1", 32'(pins16), 32'h78);

        // Enable low for 5 clocks in phase 1.
        en     = 1'b0;
        addr16 = 16'h9ABC;
        #1;
        checkOutput("en0_cen", 32'(cen16), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("en0_phase", 32'(phase16), 32'd1);
            checkOutput("en0_pins", 32'(pins16), 32'h78);
        end
        en = 1'b1;
        applyStimulus(1);
        checkOutput("resume_phase", 32'(phase16), 32'd2);
        checkOutput("resume_pins", 32'(pins16), 32'hEF);
        applyStimulus(1);
        checkOutput("resume_ph3_pins", 32'(pins16), 32'h56);
        checkOutput("resume_ph3_cen", 32'(cen16), 32'd1);
        applyStimulus(2);
        checkOutput("new_addr_ph1", 32'(pins16), 32'hBC);
        applyStimulus(1);

        // Reset pulse in phase 2.
        checkOutput("pre_rst_phase", 32'(phase16), 32'd2);
        rst = 1'b1;
        #1;
        checkOutput("rst_pulse_cen", 32'(cen16), 32'd0);
        applyStimulus(1);
        checkOutput("rst_pulse_phase", 32'(phase16), 32'd0);
        checkOutput("rst_pulse_pins", 32'(pins16), 32'hFF);
        rst = 1'b0;
        #1;
        checkOutput("after_rst_cen0", 32'(cen16), 32'd0);
        applyStimulus(1);
        checkOutput("after_rst_pins1", 32'(pins16), 32'h00);
        checkOutput("after_rst_cen1", 32'(cen16), 32'd0);
        applyStimulus(1);
        checkOutput("after_rst_pins2", 32'(pins16), 32'hFF);
        checkOutput("after_rst_cen2", 32'(cen16), 32'd0);
        applyStimulus(1);
        checkOutput("after_rst_cen3", 32'(cen16), 32'd1);
        checkOutput("after_rst_pins3", 32'(pins16), 32'h00);

        // Write data enable follows the snapshotted wr_n.
        applyStimulus(1);
        checkOutput("doe_ctrl_ef", 32'(doe16), DOE ? 32'hFF : 32'h00);
        checkOutput("dout_5a", 32'(dout16), DOE ? 32'h5A : 32'h00);
        cpuCtrl = 8'hFF;
        cpuDout = 8'hC3;
        applyStimulus(4);
        checkOutput("doe_ctrl_ff_pins", 32'(pins16), 32'hFF);
        checkOutput("doe_ctrl_ff", 32'(doe16), 32'h00);
        checkOutput("dout_c3", 32'(dout16), DOE ? 32'hC3 : 32'h00);

        // 24-bit instance: 6 phases, slices EF, CD, AB.
        en      = 1'b0;
        cpuCtrl = 8'hEF;
        en24    = 1'b1;
        #1;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 6; p++) begin
                checkOutput("a24_phase", 32'(phase24), 32'(p));
                checkOutput("a24_pins", 32'(pins24),
                            (f == 0) ? ((p % 2 == 1) ? 32'h00 : 32'hFF) : 32'(exp24[p]));
                checkOutput("a24_cen", 32'(cen24), (p == 5) ? 32'd1 : 32'd0);
                applyStimulus(1);
            end
        end
        checkOutput("a24_wrap", 32'(phase24), 32'd0);
        checkOutput("a16_frozen", 32'(phase16), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_phase_mux.md
BUS_PHASE_MUX -- requirements
Module: bus_phase_mux

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: CPU address width; must be a multiple of PIN_W.
REQ-002 SHALL have parameter PIN_W, default 8: width of the shared output pin group.
REQ-003 SHALL have parameter CTRL_W, default 8: control-word width; must equal PIN_W.
REQ-004 SHALL have parameter WR_BIT, default 4: index of active-low wr_n within the control word.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port en, input, 1: global advance enable.
REQ-008 SHALL have port hold, input, 1: frame stretch request.
REQ-009 SHALL have port cpu_ctrl, input, CTRL_W: live active-low CPU control signals.
REQ-010 SHALL have port cpu_addr, input, ADDR_W: live CPU address bus.
REQ-011 SHALL have port cpu_dout, input, PIN_W: live CPU write data.
REQ-012 SHALL have port cpu_cen, output, 1: CPU clock-enable pulse.
REQ-013 SHALL have port pins_out, output, PIN_W: time-multiplexed control/address pins.
REQ-014 SHALL have port phase, output, $clog2(NPH): current phase index.
REQ-015 SHALL have port frame_start, output, 1: high when phase==0.
REQ-016 SHALL have port data_out, output, PIN_W: snapshotted write data.
REQ-017 SHALL have port data_oe, output, PIN_W: data-pin output enable.

Function
REQ-018 SHALL derive NSLICE=ADDR_W/PIN_W and NPH=2*NSLICE (16/8 -> 4 phases).
REQ-019 SHALL advance phase by 1 per clk when en=1; wrap NPH-1 -> 0.
REQ-020 SHALL hold phase at NPH-1, assert no cpu_cen and freeze snapshots when hold=1 in phase NPH-1; hold in other phases SHALL be ignored.
REQ-021 SHALL drive cpu_cen=1 combinationally only when phase==NPH-1, en=1, hold=0, rst=0.
REQ-022 SHALL load ctrl_s<=cpu_ctrl, addr_s<=cpu_addr on every clk edge where cpu_cen=1 (pins therefore lag the CPU by exactly one frame).
REQ-023 SHALL drive pins_out=ctrl_s in even phases and addr_s[k*PIN_W +: PIN_W] in phase 2k+1 (slice 0 = LSBs first).
REQ-024 SHALL freeze phase, snapshots and outputs when en=0; cpu_cen=0.
REQ-025 SHALL keep pins_out glitch-free: a function of registered state only.

Reset
REQ-026 SHALL on rst=1 set phase=0, ctrl_s=all ones, addr_s=0, data-path snapshot=0; cpu_cen=0 while rst=1.
REQ-027 SHALL, on rst mid-frame (including during hold), abandon the frame; first cpu_cen occurs NPH-1 enabled cycles after rst falls.
REQ-028 SHALL give rst priority over en and hold.

Configuration
REQ-029 SHALL, with BUS_PHASE_MUX_DOE_EN defined, load dout_s<=cpu_dout on cpu_cen, drive data_out=dout_s and data_oe={PIN_W{~ctrl_s[WR_BIT]}}.
REQ-030 SHALL, without BUS_PHASE_MUX_DOE_EN, tie data_out=0 and data_oe=0, leave cpu_dout unused, and contain no dout_s flops.

Structure
REQ-031 SHALL place phase-encoding constants, ctrl bit-index constants (M1..BUSAK, WR_BIT default) and the control-word typedef in package bus_phase_mux_pkg.
REQ-032 SHALL implement the phase counter and cpu_cen/hold logic as sub-module bus_phase_ctr; snapshot and pin mux stay in the top.

Verification
REQ-033 SHALL check defaults, en=1, cpu_ctrl=8'hEF, cpu_addr=16'h1234 held -> after first cpu_cen, pins_out repeats EF,34,EF,12 per phase 0..3; cpu_cen once every 4 clk.
REQ-034 SHALL check hold=1 for 3 clk at phase 3 -> phase stays 3, cpu_cen=0, pins_out constant 8'h12; first cpu_cen on the cycle hold falls.
REQ-035 SHALL check en=0 for 5 clk at phase 1 -> phase, pins_out unchanged; resumes at phase 2.
REQ-036 SHALL check rst pulsed at phase 2 -> next cycle phase=0, pins_out=8'hFF, then 8'h00; cpu_cen after 3 clk.
REQ-037 SHALL check ADDR_W=24 -> 6 phases; cpu_addr=24'hABCDEF yields ctrl,EF,ctrl,CD,ctrl,AB.
REQ-038 SHALL check with BUS_PHASE_MUX_DOE_EN, cpu_ctrl=8'hEF, cpu_dout=8'h5A -> after cpu_cen data_oe=8'hFF, data_out=8'h5A; cpu_ctrl=8'hFF -> data_oe=8'h00; without macro both stay 0.
